register_dump: RTL and testbench
================================

REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001 SHALL provide parameter START_IDX, default 0, first register index dumped.
REQ-002 SHALL provide parameter END_IDX, default 31, last register index dumped; START_IDX <= END_IDX <= 31.
REQ-003 SHALL provide port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset is asynchronous and active-high.
REQ-005 SHALL provide port start  input  1  request a dump sequence; sampled only in IDLE.
REQ-006 SHALL provide port abort  input  1  terminate the dump sequence in progress.
REQ-007 SHALL provide port readAddr  output  5  register index driven to the register file read port rs1.
REQ-008 SHALL provide port readData  input  32  register file outRS1; valid one cycle after readAddr is presented.
REQ-009 SHALL provide port dumpData  output  32  captured register value.
REQ-010 SHALL provide port dumpIndex  output  5  index of the register in dumpData.
REQ-011 SHALL provide port dumpValid  output  1  dumpData/dumpIndex valid.
REQ-012 SHALL provide port dumpReady  input  1  consumer accepts the transfer.
REQ-013 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-014 SHALL provide port done  output  1  one-cycle pulse after the last transfer.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, READ, CAPTURE, OUT, DONE; all outputs are decoded from registered state only.
REQ-016 IDLE: when start=1 and abort=0, load idx=START_IDX and go to READ; otherwise stay in IDLE.
REQ-017 READ: drive readAddr=idx; go to CAPTURE on the next edge (the register file samples rs1 on this edge).
REQ-018 CAPTURE: load dumpData<=readData and dumpIndex<=idx; go to OUT.
REQ-019 OUT: assert dumpValid; transfer occurs on an edge where dumpValid=1 and dumpReady=1.
REQ-020 OUT: on transfer, if idx==END_IDX go to DONE; otherwise idx<=idx+1 and go to READ.
REQ-021 OUT: without dumpReady, dumpValid, dumpData and dumpIndex SHALL remain stable (no drop, no change).
REQ-022 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-023 readAddr SHALL equal idx in READ and CAPTURE, and hold its last value elsewhere.
REQ-024 idx SHALL be 5 bits and SHALL never increment past END_IDX (no wrap-around to 0).
REQ-025 Throughput SHALL be 3 cycles per register with dumpReady held high, giving (END_IDX-START_IDX+1)*3 cycles from leaving IDLE to entering DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and dumpValid low from that edge onward.
REQ-028 abort SHALL take priority over start and over a coincident OUT transfer; the transfer still counts as accepted.
REQ-029 The block SHALL NOT drive any write signal to the register file; it is read-only.

Reset
REQ-030 reset=1 SHALL immediately, without a clock edge, force state IDLE, idx=START_IDX, readAddr=0, dumpData=0, dumpIndex=0, dumpValid=0, busy=0 and done=0.
REQ-031 Reset asserted mid-sequence SHALL abandon the sequence; no done pulse SHALL follow deassertion.
REQ-032 After reset deassertion, a new start SHALL be required before any further read is issued.

Verification
REQ-033 Full dump: register file at its initial contents, dumpReady=1, pulse start -> 32 transfers with dumpIndex k and dumpData k, except index 29 with dumpData 252; done pulses once, 96 cycles after leaving IDLE.
REQ-034 Backpressure: dumpReady=0 for 5 cycles while index 3 is in OUT -> dumpValid=1, dumpData=3 and dumpIndex=3 stay stable; index 4 read only after dumpReady=1.
REQ-035 Abort: assert abort while index 10 is in OUT with dumpReady=0 -> IDLE next edge, busy=0, no done; start asserted during the dump before the abort has no effect.
REQ-036 Async reset: assert reset between clock edges while in OUT -> dumpValid, busy and dumpData go to 0 before the next edge; no done after release.
REQ-037 Range: START_IDX=28 and END_IDX=31 -> exactly 4 transfers, data 28, 252, 30, 31, then done.
REQ-038 Priority: start=1 and abort=1 together in IDLE -> remains in IDLE, busy=0.

Source files
------------

// File: rtl/register_dump.sv
// register_dump: walks the register file read port rs1 from START_IDX to
// END_IDX and presents each value on a valid/ready output stream.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   start      request a dump (sampled only while idle)
//   abort      end the dump in progress on the next edge
//   readAddr   register index to register file rs1
//   readData   register file outRS1, valid one cycle after readAddr
//   dumpData   captured register value
//   dumpIndex  index of the register held in dumpData
//   dumpValid  dumpData/dumpIndex valid
//   dumpReady  consumer accepts the transfer
//   busy       high whenever not idle
//   done       one-cycle pulse after the last transfer
module register_dump #(
  parameter int unsigned START_IDX = 0,
  parameter int unsigned END_IDX   = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  readAddr,
  input  logic [31:0] readData,
  output logic [31:0] dumpData,
  output logic [4:0]  dumpIndex,
  output logic        dumpValid,
  input  logic        dumpReady,
  output logic        busy,
  output logic        done
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [IDX_W-1:0] START_V = IDX_W'(START_IDX);
  localparam logic [IDX_W-1:0] END_V   = IDX_W'(END_IDX);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] OUT     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [IDX_W-1:0] idx;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort wins over start and over an OUT transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = READ;
        end
      end
      READ: begin
        state_next = abort ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        state_next = abort ? IDLE : OUT;
      end
      OUT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (dumpReady) begin
          state_next = (idx == END_V) ? DONE : READ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they track state exactly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dumpValid <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      dumpValid <= (state_next == OUT);
    end
  end

  // Index and read address: both load on entry to READ, so readAddr holds
  // idx through READ/CAPTURE and keeps its last value everywhere else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx      <= START_V;
      readAddr <= '0;
    end else if (state == IDLE && state_next == READ) begin
      idx      <= START_V;
      readAddr <= START_V;
    end else if (state == OUT && state_next == READ) begin
      idx      <= idx + IDX_W'(1);
      readAddr <= idx + IDX_W'(1);
    end
  end

  // Capture the register file output; held untouched while waiting in OUT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dumpData  <= '0;
      dumpIndex <= '0;
    end else if (state == CAPTURE) begin
      dumpData  <= DATA_W'(readData);
      dumpIndex <= idx;
    end
  end

endmodule

// File: tb/tb_register_dump.sv
module tb_register_dump;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort, dumpReady;
  logic [4:0]  readAddr, dumpIndex;
  logic [31:0] readData, dumpData;
  logic        dumpValid, busy, done;

  logic        start_r, abort_r, dumpReady_r;
  logic [4:0]  readAddr_r, dumpIndex_r;
  logic [31:0] readData_r, dumpData_r;
  logic        dumpValid_r, busy_r, done_r;

  logic [31:0] mem [32];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          stall;
    logic [4:0]  idx;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [32];

  always #5 clock = ~clock;

  register_dump dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .readAddr(readAddr), .readData(readData),
    .dumpData(dumpData), .dumpIndex(dumpIndex), .dumpValid(dumpValid),
    .dumpReady(dumpReady), .busy(busy), .done(done)
  );

  register_dump #(.START_IDX(28), .END_IDX(31)) dut_r (
    .clock(clock), .reset(reset), .start(start_r), .abort(abort_r),
    .readAddr(readAddr_r), .readData(readData_r),
    .dumpData(dumpData_r), .dumpIndex(dumpIndex_r), .dumpValid(dumpValid_r),
    .dumpReady(dumpReady_r), .busy(busy_r), .done(done_r)
  );

  // Register file read ports: synchronous, data one cycle after address
  always @(posedge clock) begin
    readData   <= mem[readAddr];
    readData_r <= mem[readAddr_r];
  end

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       sig = dumpValid;
      1:       sig = done;
      2:       sig = dumpValid_r;
      default: sig = done_r;
    endcase
  endfunction

  // Bounded wait for a DUT output to go high
  task automatic wait_sig(input int which, input string name);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 12) begin
      tick;
      n++;
    end
    checks++;
    if (sig(which) !== 1'b1) begin
      errors++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  // Full dump from the table; optionally apply the per-entry stalls
  task automatic run_dump(input bit use_stall, input string tag);
    int c0;
    int total = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    c0 = cyc;
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    for (int k = 0; k < 32; k++) begin
      wait_sig(0, $sformatf("%s_valid%0d", tag, k));
      chk($sformatf("%s_idx%0d", tag, k), 32'(dumpIndex), 32'(tbl[k].idx));
      chk($sformatf("%s_data%0d", tag, k), dumpData, tbl[k].data);
      chk($sformatf("%s_raddr%0d", tag, k), 32'(readAddr), 32'(tbl[k].idx));
      if (use_stall && tbl[k].stall > 0) begin
        dumpReady = 1'b0;
        total += tbl[k].stall;
        for (int s = 0; s < tbl[k].stall; s++) begin
          tick;
          chk($sformatf("%s_hold_valid%0d", tag, s), 32'(dumpValid), 32'(1));
          chk($sformatf("%s_hold_data%0d", tag, s), dumpData, tbl[k].data);
          chk($sformatf("%s_hold_idx%0d", tag, s), 32'(dumpIndex), 32'(tbl[k].idx));
          chk($sformatf("%s_hold_raddr%0d", tag, s), 32'(readAddr), 32'(tbl[k].idx));
        end
        dumpReady = 1'b1;
      end
      tick;
    end
    wait_sig(1, {tag, "_done"});
    chk({tag, "_cycles"}, 32'(cyc - c0), 32'(96 + total));
    tick;
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    logic        seen;
    logic [31:0] rexp [4];

    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'(i);
      tbl[i].stall = (i == 3) ? 5 : 0;
      tbl[i].idx   = 5'(i);
      tbl[i].data  = (i == 29) ? 32'd252 : 32'(i);
    end
    mem[29] = 32'd252;
    rexp[0] = 32'd28; rexp[1] = 32'd252; rexp[2] = 32'd30; rexp[3] = 32'd31;

    reset = 1'b1; start = 1'b0; abort = 1'b0; dumpReady = 1'b1;
    start_r = 1'b0; abort_r = 1'b0; dumpReady_r = 1'b1;
    tick;
    tick;
    chk("rst_valid", 32'(dumpValid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_data", dumpData, 32'(0));
    chk("rst_index", 32'(dumpIndex), 32'(0));
    chk("rst_raddr", 32'(readAddr), 32'(0));
    reset = 1'b0;
    tick;
    chk("post_rst_busy", 32'(busy), 32'(0));

    // Full dump with ready held high, then again with backpressure on index 3
    run_dump(1'b0, "full");
    tick;
    run_dump(1'b1, "bp");
    tick;

    // Abort at index 10 while stalled; a start mid-dump must be ignored
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      wait_sig(0, $sformatf("ab_valid%0d", k));
      chk($sformatf("ab_idx%0d", k), 32'(dumpIndex), 32'(k));
      if (k == 1) start = 1'b1;
      if (k < 10) tick;
      start = 1'b0;
    end
    dumpReady = 1'b0;
    tick;
    chk("ab_stall_valid", 32'(dumpValid), 32'(1));
    abort = 1'b1;
    tick;
    abort = 1'b0;
    dumpReady = 1'b1;
    chk("ab_busy", 32'(busy), 32'(0));
    chk("ab_valid", 32'(dumpValid), 32'(0));
    chk("ab_done", 32'(done), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | done | busy | dumpValid;
    end
    chk("ab_quiet", 32'(seen), 32'(0));

    // Asynchronous reset between edges while index 2 is in OUT
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_sig(0, $sformatf("ar_valid%0d", k));
      if (k < 2) tick;
    end
    chk("ar_pre_data", dumpData, 32'(2));
    #3 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(dumpValid), 32'(0));
    chk("ar_busy", 32'(busy), 32'(0));
    chk("ar_data", dumpData, 32'(0));
    chk("ar_index", 32'(dumpIndex), 32'(0));
    chk("ar_raddr", 32'(readAddr), 32'(0));
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen = seen | done | busy | dumpValid | (readAddr != 5'd0);
    end
    chk("ar_quiet", 32'(seen), 32'(0));

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick;
    chk("pri_busy0", 32'(busy), 32'(0));
    tick;
    chk("pri_busy1", 32'(busy), 32'(0));
    start = 1'b0;
    abort = 1'b0;
    tick;
    chk("pri_busy2", 32'(busy), 32'(0));

    // Partial range 28..31
    start_r = 1'b1;
    tick;
    start_r = 1'b0;
    begin
      int c0;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
        wait_sig(2, $sformatf("rg_valid%0d", k));
        chk($sformatf("rg_idx%0d", k), 32'(dumpIndex_r), 32'(28 + k));
        chk($sformatf("rg_data%0d", k), dumpData_r, rexp[k]);
        tick;
      end
      wait_sig(3, "rg_done");
      chk("rg_cycles", 32'(cyc - c0), 32'(12));
    end
    tick;
    chk("rg_idle", 32'(busy_r), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      seen = seen | dumpValid_r | done_r;
    end
    chk("rg_quiet", 32'(seen), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
